// File: rtl/reg_scoreboard.sv
// Register scoreboard for long-latency channels: per-channel in-order FIFOs of
// destination registers, a pending-write mask, and the decode hazard stall.
module reg_scoreboard #(
    parameter int NUM_CH = 2,
    parameter int DEPTH  = 4,
    localparam int CNT_W = $clog2(DEPTH) + 1,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              rs1_id,
    input  logic [4:0]              rs2_id,
    input  logic [4:0]              rd_id,
    input  logic                    use_rs1_id,
    input  logic                    use_rs2_id,
    input  logic                    reg_write_id,
    input  logic                    issue_valid,
    input  logic [CH_W-1:0]         issue_ch,
    input  logic                    stall_pipl,
    input  logic [NUM_CH-1:0]       cmpl_valid,
    output logic                    stall_o,
    output logic [5*NUM_CH-1:0]     cmpl_rd,
    output logic [31:0]             pending_o,
    output logic [CNT_W*NUM_CH-1:0] ch_count,
    output logic [NUM_CH-1:0]       ch_full,
    output logic                    idle,
    output logic                    err_underflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pending_q, pending_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] count_q  [NUM_CH];
    logic [CNT_W-1:0] count_d  [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_q [NUM_CH];
    logic [PTR_W-1:0] rd_ptr_d [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_q [NUM_CH];
    logic [PTR_W-1:0] wr_ptr_d [NUM_CH];
    logic [4:0]       mem_q    [NUM_CH][DEPTH];
    logic [4:0]       mem_d    [NUM_CH][DEPTH];

    logic [(2**CH_W)-1:0] full_pad;
    logic                 ch_in_range;
    logic                 issue_acc;
    logic                 push;
    logic                 pop;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_out
        assign cmpl_rd[5*c +: 5]          = mem_q[c][rd_ptr_q[c]];
        assign ch_count[CNT_W*c +: CNT_W] = count_q[c];
        assign ch_full[c]                 = (count_q[c] == CNT_W'(DEPTH));
    end

    // Padding lets issue_ch index the full flags even when NUM_CH is not a power of two.
    assign full_pad      = (2**CH_W)'(ch_full);
    assign ch_in_range   = (32'(issue_ch) < NUM_CH);
    assign pending_o     = pending_q;
    assign idle          = ~|ch_count;
    assign err_underflow = err_q;

    // Hazards are judged on registered state only; no same-cycle completion bypass.
    assign stall_o = (use_rs1_id   & pending_q[rs1_id])
                   | (use_rs2_id   & pending_q[rs2_id])
                   | (reg_write_id & pending_q[rd_id])
                   | (issue_valid  & full_pad[issue_ch]);

    assign issue_acc = issue_valid & ~stall_o & ~stall_pipl & ch_in_range;

    always_comb begin
        pending_d = pending_q;
        err_d     = err_q;
        count_d   = count_q;
        rd_ptr_d  = rd_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        mem_d     = mem_q;
        push      = 1'b0;
        pop       = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            push = issue_acc && (issue_ch == CH_W'(c));
            pop  = cmpl_valid[c] && (count_q[c] != '0);
            if (cmpl_valid[c] && (count_q[c] == '0)) begin
                err_d = 1'b1;
            end
            if (push) begin
                mem_d[c][wr_ptr_q[c]] = rd_id;
                wr_ptr_d[c]           = wr_ptr_q[c] + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d[c]                       = rd_ptr_q[c] + PTR_W'(1);
                pending_d[mem_q[c][rd_ptr_q[c]]] = 1'b0;
            end
            count_d[c] = count_q[c] + CNT_W'(push) - CNT_W'(pop);
        end
        // Set is applied after all clears so it wins on the same register.
        if (issue_acc) begin
            pending_d[rd_id] = 1'b1;
        end
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '0;
            err_q     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                count_q[c]  <= '0;
                rd_ptr_q[c] <= '0;
                wr_ptr_q[c] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            err_q     <= err_d;
            count_q   <= count_d;
            rd_ptr_q  <= rd_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Randomized and directed bench for reg_scoreboard against a queue-based
// model where pending registers are simply the contents of the channel queues.
module tb_reg_scoreboard;

  localparam int NUM_CH = 2;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int CH_W   = 1;

  logic                    clk;
  logic                    reset;
  logic [4:0]              rs1_id, rs2_id, rd_id;
  logic                    use_rs1_id, use_rs2_id, reg_write_id;
  logic                    issue_valid;
  logic [CH_W-1:0]         issue_ch;
  logic                    stall_pipl;
  logic [NUM_CH-1:0]       cmpl_valid;
  logic                    stall_o;
  logic [5*NUM_CH-1:0]     cmpl_rd;
  logic [31:0]             pending_o;
  logic [CNT_W*NUM_CH-1:0] ch_count;
  logic [NUM_CH-1:0]       ch_full;
  logic                    idle;
  logic                    err_underflow;

  int n_total = 0;
  int n_bad   = 0;

  int mq [NUM_CH][$];
  bit m_err;

  reg_scoreboard #(.NUM_CH(NUM_CH), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .rs1_id        (rs1_id),
    .rs2_id        (rs2_id),
    .rd_id         (rd_id),
    .use_rs1_id    (use_rs1_id),
    .use_rs2_id    (use_rs2_id),
    .reg_write_id  (reg_write_id),
    .issue_valid   (issue_valid),
    .issue_ch      (issue_ch),
    .stall_pipl    (stall_pipl),
    .cmpl_valid    (cmpl_valid),
    .stall_o       (stall_o),
    .cmpl_rd       (cmpl_rd),
    .pending_o     (pending_o),
    .ch_count      (ch_count),
    .ch_full       (ch_full),
    .idle          (idle),
    .err_underflow (err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_pend(input int r);
    if (r == 0) return 1'b0;
    for (int c = 0; c < NUM_CH; c++)
      for (int i = 0; i < mq[c].size(); i++)
        if (mq[c][i] == r) return 1'b1;
    return 1'b0;
  endfunction

  task automatic check_state();
    logic [31:0] exp_pend;
    int total;
    exp_pend = '0;
    total = 0;
    for (int r = 1; r < 32; r++) exp_pend[r] = m_pend(r);
    check("pending_o", pending_o, exp_pend);
    for (int c = 0; c < NUM_CH; c++) begin
      total += mq[c].size();
      check($sformatf("ch_count[%0d]", c), 32'(ch_count[CNT_W*c +: CNT_W]), 32'(mq[c].size()));
      check($sformatf("ch_full[%0d]", c), 32'(ch_full[c]), 32'(mq[c].size() == DEPTH));
      if (mq[c].size() > 0)
        check($sformatf("cmpl_rd[%0d]", c), 32'(cmpl_rd[5*c +: 5]), 32'(mq[c][0]));
    end
    check("idle", 32'(idle), 32'(total == 0));
    check("err_underflow", 32'(err_underflow), 32'(m_err));
  endtask

  task automatic do_cycle(input bit rst, input int r1, input int r2, input int rd,
                          input bit u1, input bit u2, input bit w, input bit iv,
                          input int ch, input bit sp, input int cv);
    bit exp_stall;
    @(negedge clk);
    reset        = rst;
    rs1_id       = 5'(r1);
    rs2_id       = 5'(r2);
    rd_id        = 5'(rd);
    use_rs1_id   = u1;
    use_rs2_id   = u2;
    reg_write_id = w;
    issue_valid  = iv;
    issue_ch     = CH_W'(ch);
    stall_pipl   = sp;
    cmpl_valid   = NUM_CH'(cv);
    exp_stall = (u1 && m_pend(r1)) || (u2 && m_pend(r2)) || (w && m_pend(rd))
             || (iv && mq[ch].size() == DEPTH);
    #1;
    check("stall_o", 32'(stall_o), 32'(exp_stall));
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) mq[c].delete();
      m_err = 1'b0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cv[c]) begin
          if (mq[c].size() > 0) void'(mq[c].pop_front());
          else m_err = 1'b1;
        end
      end
      if (iv && !exp_stall && !sp) mq[ch].push_back(rd);
    end
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic nop(input int cv);
    do_cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, cv);
  endtask

  task automatic issue(input int rd, input int ch, input int cv);
    do_cycle(0, 0, 0, rd, 0, 0, 1, 1, ch, 0, cv);
  endtask

  initial begin
    reset = 1'b1; rs1_id = '0; rs2_id = '0; rd_id = '0;
    use_rs1_id = 1'b0; use_rs2_id = 1'b0; reg_write_id = 1'b0;
    issue_valid = 1'b0; issue_ch = '0; stall_pipl = 1'b0; cmpl_valid = '0;
    m_err = 1'b0;

    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // RAW on r5 through channel 0
    issue(5, 0, 0);
    do_cycle(0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 1);
    do_cycle(0, 5, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    // Fill channel 1, then issue alongside a completion while full
    for (int r = 1; r <= 4; r++) issue(r, 1, 0);
    issue(6, 1, 2);
    issue(6, 1, 0);
    for (int i = 0; i < 4; i++) nop(2);

    // Order across pointer wrap on channel 0
    issue(10, 0, 0);
    issue(11, 0, 0);
    issue(12, 0, 1);
    issue(13, 0, 0);
    issue(14, 0, 1);
    issue(15, 0, 1);
    for (int i = 0; i < 4; i++) nop(1);

    // Underflow and its persistence
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    nop(2);
    nop(0);
    issue(7, 1, 0);
    nop(2);
    nop(3);

    // Hold, x0 issue, then reset with outstanding entries
    do_cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    do_cycle(0, 0, 0, 7, 0, 0, 1, 1, 0, 1, 0);
    issue(0, 0, 0);
    issue(3, 1, 0);
    issue(4, 1, 0);
    do_cycle(1, 0, 0, 9, 0, 0, 1, 1, 0, 0, 3);
    nop(0);

    for (int n = 0; n < 3000; n++) begin
      bit iv;
      iv = 1'($urandom_range(0, 1));
      do_cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               iv | 1'($urandom_range(0, 1)), iv,
               $urandom_range(0, NUM_CH - 1), $urandom_range(0, 9) == 0,
               int'($urandom_range(0, 2) == 0) | (int'($urandom_range(0, 2) == 0) << 1));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
